// File: rtl/lsio_btn_debounce.sv
// lsio_btn_debounce: button pin synchroniser, free-running 1 ms tick and
// confirm-for-N-ms debouncer with press/release pulses.  Rev 1.0
`default_nettype none

module lsio_btn_debounce #(
   parameter int CLKS_PER_MS = 50000,
   parameter int DEBOUNCE_MS = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_raw_i,
   input  logic       clear_i,
   output logic       one_ms_event_o,
   output logic       btn_o,
   output logic       press_o,
   output logic       release_o,
   output logic [7:0] bounce_cnt_o
);

   localparam int   c_TW       = $clog2(CLKS_PER_MS);
   localparam int   c_MW       = $clog2(DEBOUNCE_MS + 1);
   localparam logic c_INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      REL    = 2'd0,
      CONF_P = 2'd1,
      PRS    = 2'd2,
      CONF_R = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [c_TW-1:0]        r_tick_cnt;
   logic [c_MW-1:0]        r_ms_cnt;
   state_t                 r_state;
   logic                   w_s;
   logic                   w_tick;
   logic                   w_done;
   logic                   w_abort;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= {SYNC_STAGES{c_INACTIVE}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw_i};
      end
   end

   // s is in pressed-sense: 1 means the button is held.
   assign w_s = r_sync[SYNC_STAGES-1] ^ c_INACTIVE;

   assign w_tick = (r_tick_cnt == c_TW'(CLKS_PER_MS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tick_cnt     <= '0;
         one_ms_event_o <= 1'b0;
      end else begin
         one_ms_event_o <= w_tick;
         if (w_tick) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + c_TW'(1);
         end
      end
   end

   assign w_done  = (r_ms_cnt == c_MW'(DEBOUNCE_MS - 1));
   assign w_abort = ((r_state == CONF_P) && !w_s) || ((r_state == CONF_R) && w_s);

   // A level change in a CONF state takes priority over a coincident tick.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= REL;
         r_ms_cnt  <= '0;
         btn_o     <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
      end else begin
         press_o   <= 1'b0;
         release_o <= 1'b0;
         case (r_state)
            REL: begin
               if (w_s) begin
                  r_state  <= CONF_P;
                  r_ms_cnt <= '0;
               end
            end
            CONF_P: begin
               if (!w_s) begin
                  r_state <= REL;
               end else if (w_tick) begin
                  if (w_done) begin
                     r_state  <= PRS;
                     r_ms_cnt <= '0;
                     btn_o    <= 1'b1;
                     press_o  <= 1'b1;
                  end else begin
                     r_ms_cnt <= r_ms_cnt + c_MW'(1);
                  end
               end
            end
            PRS: begin
               if (!w_s) begin
                  r_state  <= CONF_R;
                  r_ms_cnt <= '0;
               end
            end
            CONF_R: begin
               if (w_s) begin
                  r_state <= PRS;
               end else if (w_tick) begin
                  if (w_done) begin
                     r_state   <= REL;
                     r_ms_cnt  <= '0;
                     btn_o     <= 1'b0;
                     release_o <= 1'b1;
                  end else begin
                     r_ms_cnt <= r_ms_cnt + c_MW'(1);
                  end
               end
            end
            default: begin
               r_state  <= REL;
               r_ms_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bounce_cnt_o <= 8'd0;
      end else if (clear_i) begin
         bounce_cnt_o <= 8'd0;
      end else if (w_abort && (bounce_cnt_o != 8'hFF)) begin
         bounce_cnt_o <= bounce_cnt_o + 8'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lsio_btn_debounce.sv
// tb_lsio_btn_debounce: directed and randomized checks of the button front end
// against a run-length reference model.
`default_nettype none

module tb_lsio_btn_debounce;

   localparam int CLKS = 10;
   localparam int DEB  = 3;
   localparam int SYNC = 2;
   localparam int AL   = 1;

   logic       clk;
   logic       rst;
   logic       btn_raw;
   logic       clear;
   logic       one_ms_event;
   logic       btn;
   logic       press;
   logic       rel;
   logic [7:0] bounce_cnt;

   lsio_btn_debounce #(
      .CLKS_PER_MS (CLKS),
      .DEBOUNCE_MS (DEB),
      .SYNC_STAGES (SYNC),
      .ACTIVE_LOW  (AL)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .btn_raw_i      (btn_raw),
      .clear_i        (clear),
      .one_ms_event_o (one_ms_event),
      .btn_o          (btn),
      .press_o        (press),
      .release_o      (rel),
      .bounce_cnt_o   (bounce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: s is the pin delayed by the synchroniser; a candidate
   // level is accepted once DEB ticks have occurred during a stable run of s
   // that disagrees with the accepted level (the run's first cycle excluded).
   int m_t         = 0;
   bit m_pinq[$]   = '{1'b1, 1'b1};
   bit m_prev_s    = 1'b0;
   int m_run_ticks = 0;
   bit m_btn       = 1'b0;
   bit m_press     = 1'b0;
   bit m_rel       = 1'b0;
   bit m_event     = 1'b0;
   int m_bounce    = 0;

   function automatic bit pressed(input bit pin);
      return (AL != 0) ? !pin : pin;
   endfunction

   always @(posedge clk) begin
      bit s_now;
      bit tick;
      bit abort;
      if (rst) begin
         m_t         = 0;
         m_pinq      = {};
         for (int i = 0; i < SYNC; i++) m_pinq.push_back((AL != 0) ? 1'b1 : 1'b0);
         m_prev_s    = 1'b0;
         m_run_ticks = 0;
         m_btn       = 1'b0;
         m_press     = 1'b0;
         m_rel       = 1'b0;
         m_event     = 1'b0;
         m_bounce    = 0;
      end else begin
         s_now   = pressed(m_pinq[0]);
         tick    = ((m_t % CLKS) == CLKS - 1);
         abort   = 1'b0;
         m_event = tick;
         m_press = 1'b0;
         m_rel   = 1'b0;
         if (s_now != m_prev_s) begin
            abort       = (m_prev_s != m_btn);
            m_run_ticks = 0;
         end else if ((s_now != m_btn) && tick) begin
            m_run_ticks++;
            if (m_run_ticks == DEB) begin
               m_btn       = s_now;
               m_press     = s_now;
               m_rel       = !s_now;
               m_run_ticks = 0;
            end
         end
         if (clear)                        m_bounce = 0;
         else if (abort && m_bounce < 255) m_bounce++;
         void'(m_pinq.pop_front());
         m_pinq.push_back(btn_raw);
         m_prev_s = s_now;
         m_t++;
      end
      #1;
      chk("one_ms_event", int'(one_ms_event), int'(m_event));
      chk("btn",          int'(btn),          int'(m_btn));
      chk("press",        int'(press),        int'(m_press));
      chk("release",      int'(rel),          int'(m_rel));
      chk("bounce_cnt",   int'(bounce_cnt),   m_bounce);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int k;
      int lat;
      int cnt;
      int b0;
      rst     = 1'b1;
      btn_raw = 1'b1;
      clear   = 1'b0;
      step(3);
      chk("reset_btn",    int'(btn), 0);
      chk("reset_event",  int'(one_ms_event), 0);
      chk("reset_bounce", int'(bounce_cnt), 0);
      rst = 1'b0;

      // Idle: tick pulses on cycles 10 and 20 only.
      while (m_t < 10) step(1);
      chk("event_cycle10", int'(one_ms_event), 1);
      step(1);
      chk("event_cycle11", int'(one_ms_event), 0);
      while (m_t < 20) step(1);
      chk("event_cycle20", int'(one_ms_event), 1);
      chk("idle_btn", int'(btn), 0);

      // Clean press: hold time (20,30] plus 2 sync cycles and 1 entry cycle.
      btn_raw = 1'b0;
      k   = m_t;
      lat = -1;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (btn && lat < 0) begin
            lat = m_t - k;
            chk("press_with_btn", int'(press), 1);
         end
      end
      chk("press_latency_window", int'(lat >= 24 && lat <= 33), 1);
      btn_raw = 1'b1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (rel) cnt++;
      end
      chk("release_count", cnt, 1);
      chk("released_btn", int'(btn), 0);

      // Toggling every 4 cycles: five low phases, five aborted confirmations.
      b0 = bounce_cnt;
      for (int i = 0; i < 10; i++) begin
         btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(4);
      end
      btn_raw = 1'b1;
      step(40);
      chk("toggle_btn", int'(btn), 0);
      chk("toggle_bounces", int'(bounce_cnt) - b0, 5);

      // Release on exactly the cycle the completing tick would land.
      b0 = bounce_cnt;
      while ((m_t % CLKS) != 6) step(1);
      btn_raw = 1'b0;
      step(21);
      btn_raw = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (press) cnt++;
      end
      chk("tick_tie_no_press", cnt, 0);
      chk("tick_tie_bounce", int'(bounce_cnt) - b0, 1);

      // Saturation, then clear against a simultaneous abort.
      for (int i = 0; i < 300; i++) begin
         btn_raw = 1'b0;
         step(3);
         btn_raw = 1'b1;
         step(3);
      end
      step(2);
      chk("bounce_saturated", int'(bounce_cnt), 255);
      clear   = 1'b1;
      btn_raw = 1'b0;
      step(3);
      btn_raw = 1'b1;
      step(5);
      clear = 1'b0;
      step(1);
      chk("clear_wins", int'(bounce_cnt), 0);
      btn_raw = 1'b0;
      step(3);
      btn_raw = 1'b1;
      step(5);
      chk("count_after_clear", int'(bounce_cnt), 1);

      // One-cycle glitch while pressed.
      btn_raw = 1'b0;
      step(40);
      chk("held_btn", int'(btn), 1);
      b0 = bounce_cnt;
      btn_raw = 1'b1;
      step(1);
      btn_raw = 1'b0;
      step(10);
      chk("glitch_btn", int'(btn), 1);
      chk("glitch_bounce", int'(bounce_cnt) - b0, 1);

      // Reset while held: outputs clear with no release, re-press at cycle 30.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("rst_btn", int'(btn), 0);
         chk("rst_release", int'(rel), 0);
         chk("rst_bounce", int'(bounce_cnt), 0);
      end
      rst = 1'b0;
      lat = -1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (rel) cnt++;
         if (btn && lat < 0) lat = m_t;
      end
      chk("rst_no_release", cnt, 0);
      chk("rst_repress_cycle", lat, 30);

      // Randomized pin activity, clears and occasional resets.
      for (int i = 0; i < 120; i++) begin
         int dur;
         dur     = $urandom_range(1, 35);
         btn_raw = 1'($urandom_range(0, 1));
         for (int j = 0; j < dur; j++) begin
            clear = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            step(1);
         end
      end
      rst   = 1'b0;
      clear = 1'b0;
      step(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
